// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports (p0 = pipeline MEM stage,
// p1 = debug/loader) and the single-ported data-memory bus of dmem_arbiter.
//
// Handshake: a requester raises pX_req with pX_we/pX_addr/pX_wdata and holds
// all of them stable until it sees pX_gnt (a one-cycle pulse). pX_stall is
// pX_req & ~pX_gnt. req may drop in the gnt cycle. The result arrives as a
// one-cycle pX_rvalid pulse two cycles after gnt, with pX_rdata holding the
// load data (0 for a store) until the next pulse for that port. On the memory
// side mem_en is a one-cycle strobe and mem_rdata is valid the cycle after it.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    // port 0
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_stall;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    // port 1
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_stall;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    // memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_stall, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_stall, p1_rvalid, p1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // requester + memory side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_stall, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_stall, p1_rvalid, p1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// One access in flight at a time: IDLE/RESP -> ACC -> WAIT -> RESP, giving
// gnt one cycle and rvalid three cycles after the request is sampled.
// Optional macro DMEM_RR_ARB_EN: ties go to the port not granted most
// recently; without it port 0 always wins ties.
// dbg_state exposes the FSM state (IDLE=0, ACC=1, WAIT=2, RESP=3).
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              id_q, id_d;          // winner: 0 = port 0, 1 = port 1
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              pick_p1;

`ifdef DMEM_RR_ARB_EN
    logic              last_q, last_d;      // port granted most recently

    // Winner selection: a lone request wins, ties go to the other port than last time
    always_comb begin
        pick_p1 = bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            pick_p1 = ~last_q;
        end
    end
`else
    // Winner selection: port 1 only wins when port 0 is not requesting
    always_comb begin
        pick_p1 = bus.p1_req & ~bus.p0_req;
    end
`endif

    // Next-state logic: arbitrate in IDLE/RESP, strobe memory in ACC, capture in WAIT
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
`ifdef DMEM_RR_ARB_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE, RESP: begin
                if (bus.p0_req || bus.p1_req) begin
                    state_d = ACC;
                    id_d    = pick_p1;
                    we_d    = pick_p1 ? bus.p1_we    : bus.p0_we;
                    addr_d  = pick_p1 ? bus.p1_addr  : bus.p0_addr;
                    wdata_d = pick_p1 ? bus.p1_wdata : bus.p0_wdata;
`ifdef DMEM_RR_ARB_EN
                    last_d  = pick_p1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                state_d = WAIT;
            end
            WAIT: begin
                // a store reports 0 so the requester never sees stale load data
                if (id_q) begin
                    p1_rdata_d = we_q ? '0 : bus.mem_rdata;
                end else begin
                    p0_rdata_d = we_q ? '0 : bus.mem_rdata;
                end
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            id_q       <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
`ifdef DMEM_RR_ARB_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            id_q       <= id_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
`ifdef DMEM_RR_ARB_EN
            last_q     <= last_d;
`endif
        end
    end

    // Outputs decoded from state: memory bus is zero outside ACC
    always_comb begin
        bus.mem_en    = (state_q == ACC);
        bus.mem_we    = (state_q == ACC) & we_q;
        bus.mem_addr  = (state_q == ACC) ? addr_q  : '0;
        bus.mem_wdata = (state_q == ACC) ? wdata_q : '0;

        bus.p0_gnt    = (state_q == ACC)  & ~id_q;
        bus.p1_gnt    = (state_q == ACC)  &  id_q;
        bus.p0_rvalid = (state_q == RESP) & ~id_q;
        bus.p1_rvalid = (state_q == RESP) &  id_q;
        bus.p0_stall  = bus.p0_req & ~bus.p0_gnt;
        bus.p1_stall  = bus.p1_req & ~bus.p1_gnt;
        bus.p0_rdata  = p0_rdata_q;
        bus.p1_rdata  = p1_rdata_q;

        dbg_state     = state_q;
    end

endmodule
